// File: rtl/noc_local_depacketizer.sv
// Local-port ejection stage: turns router flits (header/body/tail) into a framed payload stream.
// Filters misrouted/malformed packets, tags each beat with its source node, keeps packet counters.
//
// state  | meaning
// S_IDLE | waiting for a header
// S_BODY | inside an accepted packet, body flits go through the hold register
// S_DROP | inside a misrouted packet, discarding until its tail
module noc_local_depacketizer #(
   parameter int DATA_W    = 64,
   parameter int X_W       = 2,
   parameter int Y_W       = 2,
   parameter int SRC_LSB   = 56,
   parameter int OUT_DEPTH = 4
) (
   input  logic              noc_clk,
   input  logic              noc_rst,
   input  logic [X_W-1:0]    my_x,
   input  logic [Y_W-1:0]    my_y,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W+1:0] in_flit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_err,
   output logic [X_W-1:0]    out_src_x,
   output logic [Y_W-1:0]    out_src_y,
   output logic              pkt_done,
   output logic              err_pulse,
   output logic [15:0]       pkt_cnt,
   output logic [15:0]       drop_cnt
);

   localparam int ID_W    = X_W + Y_W;
   localparam int DST_LSB = SRC_LSB - ID_W;
   localparam int PTR_W   = $clog2(OUT_DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(OUT_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

   state_t            state;
   logic              hold_valid;
   logic [DATA_W-1:0] hold_data;
   logic [ID_W-1:0]   cur_src;

   logic              acc;
   logic              is_hdr;
   logic              is_tl;
   logic              dst_ok;
   logic [DATA_W-1:0] payload;
   logic [ID_W-1:0]   hdr_src;

   logic              push;
   logic              push_last;
   logic              push_err;
   logic              pop;

   logic [DATA_W-1:0] mem_data [OUT_DEPTH];
   logic              mem_last [OUT_DEPTH];
   logic              mem_err  [OUT_DEPTH];
   logic [ID_W-1:0]   mem_src  [OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W:0]    count_nxt;
   logic [ID_W-1:0]   src_rd;

   always_comb begin
      acc     = in_valid & in_ready;
      is_hdr  = in_flit[DATA_W+1];
      is_tl   = in_flit[DATA_W];
      payload = in_flit[DATA_W-1:0];
      hdr_src = in_flit[SRC_LSB +: ID_W];
      dst_ok  = (in_flit[DST_LSB +: ID_W] == {my_x, my_y});
   end

   // The held beat leaves on the next accepted flit of the packet; any header
   // arriving while a packet is open marks it truncated.
   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_err  = 1'b0;
      if (acc && (state == S_BODY) && hold_valid) begin
         push = 1'b1;
         if (is_hdr) begin
            push_last = 1'b1;
            push_err  = 1'b1;
         end else if (is_tl) begin
            push_last = 1'b1;
         end
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         state      <= S_IDLE;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         cur_src    <= '0;
         pkt_done   <= 1'b0;
         err_pulse  <= 1'b0;
         pkt_cnt    <= '0;
         drop_cnt   <= '0;
      end else begin
         pkt_done  <= 1'b0;
         err_pulse <= 1'b0;
         if (acc) begin
            if (is_hdr) begin
               if (state == S_BODY) err_pulse <= 1'b1;
               hold_valid <= 1'b0;
               if (dst_ok) begin
                  cur_src <= hdr_src;
                  if (is_tl) begin
                     pkt_done <= 1'b1;
                     pkt_cnt  <= pkt_cnt + 16'd1;
                     state    <= S_IDLE;
                  end else begin
                     state <= S_BODY;
                  end
               end else begin
                  err_pulse <= 1'b1;
                  if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                  state <= is_tl ? S_IDLE : S_DROP;
               end
            end else begin
               case (state)
                  S_IDLE: begin
                     err_pulse <= 1'b1;
                     if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                  end
                  S_BODY: begin
                     if (is_tl) begin
                        hold_valid <= 1'b0;
                        pkt_done   <= 1'b1;
                        pkt_cnt    <= pkt_cnt + 16'd1;
                        state      <= S_IDLE;
                     end else begin
                        hold_data  <= payload;
                        hold_valid <= 1'b1;
                     end
                  end
                  S_DROP: begin
                     if (is_tl) state <= S_IDLE;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign pop       = out_valid & out_ready;
   assign count_nxt = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

   // in_ready looks at the post-update occupancy so a push can never land on a full FIFO.
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_nxt;
         in_ready <= (count_nxt != CNT_FULL);
      end
   end

   always_ff @(posedge noc_clk) begin
      if (push) begin
         mem_data[wr_ptr] <= hold_data;
         mem_last[wr_ptr] <= push_last;
         mem_err[wr_ptr]  <= push_err;
         mem_src[wr_ptr]  <= cur_src;
      end
   end

   assign src_rd    = mem_src[rd_ptr];
   assign out_valid = (count != '0);
   assign out_data  = mem_data[rd_ptr];
   assign out_last  = out_valid & mem_last[rd_ptr];
   assign out_err   = out_valid & mem_err[rd_ptr];
   assign out_src_x = src_rd[ID_W-1:Y_W];
   assign out_src_y = src_rd[Y_W-1:0];

endmodule

// File: tb/tb_noc_local_depacketizer.sv
// Bench for noc_local_depacketizer: packet table plus hand-written corner sequences,
// output beats checked against a queue of expected beats.
module tb_noc_local_depacketizer;

   logic        noc_clk = 1'b0;
   logic        noc_rst = 1'b1;
   logic [1:0]  my_x = 2'd1;
   logic [1:0]  my_y = 2'd2;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [65:0] in_flit = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        out_last;
   logic        out_err;
   logic [1:0]  out_src_x;
   logic [1:0]  out_src_y;
   logic        pkt_done;
   logic        err_pulse;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;

   noc_local_depacketizer dut (
      .noc_clk(noc_clk), .noc_rst(noc_rst), .my_x(my_x), .my_y(my_y),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_err(out_err), .out_src_x(out_src_x), .out_src_y(out_src_y),
      .pkt_done(pkt_done), .err_pulse(err_pulse), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 noc_clk = ~noc_clk;

   typedef struct {
      logic [1:0] sx, sy, dx, dy;
      int         nbody;
      bit         good;
   } pkt_t;

   int n_checks = 0;
   int n_pass = 0;
   int done_seen = 0;
   int err_seen = 0;
   int acc_cnt = 0;
   int exp_pkt = 0, exp_drop = 0, exp_done = 0, exp_err = 0;
   logic [69:0] exp_q [$];
   logic [63:0] d;
   logic [63:0] bp_first;
   bit snd_done;
   pkt_t tbl [7];

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   function automatic logic [63:0] hdr_pl(input logic [1:0] sx, input logic [1:0] sy,
                                          input logic [1:0] dx, input logic [1:0] dy);
      logic [63:0] p;
      p = {$urandom, $urandom};
      p[59:56] = {sx, sy};
      p[55:52] = {dx, dy};
      return p;
   endfunction

   // Caller is at a negedge; returns at the negedge after acceptance.
   task automatic send(input bit h, input bit t, input logic [63:0] p);
      int w = 0;
      in_valid = 1'b1;
      in_flit  = {h, t, p};
      while (!in_ready && w < 400) begin
         @(negedge noc_clk);
         w++;
      end
      if (w >= 400) chk("in_ready_timeout", in_ready, 1'b1);
      @(negedge noc_clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      repeat (2) @(negedge noc_clk);
      while ((exp_q.size() != 0 || out_valid) && w < 200) begin
         @(negedge noc_clk);
         w++;
      end
      if (w >= 200) chk("drain_done", {exp_q.size() != 0, out_valid}, 2'b00);
      repeat (2) @(negedge noc_clk);
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
      chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
      chk({tag, "_pkt_done_pulses"}, done_seen, exp_done);
      chk({tag, "_err_pulses"}, err_seen, exp_err);
   endtask

   always @(negedge noc_clk) begin
      if (!noc_rst) begin
         if (pkt_done) done_seen++;
         if (err_pulse) err_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", out_valid, 1'b0);
            else chk("beat", {out_data, out_last, out_err, out_src_x, out_src_y}, exp_q.pop_front());
         end
      end
   end

   always @(posedge noc_clk) if (!noc_rst && in_valid && in_ready) acc_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{sx:2'd3, sy:2'd0, dx:2'd1, dy:2'd2, nbody:3, good:1'b1};
      tbl[1] = '{sx:2'd0, sy:2'd1, dx:2'd2, dy:2'd2, nbody:2, good:1'b0};
      tbl[2] = '{sx:2'd2, sy:2'd3, dx:2'd1, dy:2'd2, nbody:1, good:1'b1};
      tbl[3] = '{sx:2'd1, sy:2'd1, dx:2'd1, dy:2'd2, nbody:0, good:1'b1};
      tbl[4] = '{sx:2'd0, sy:2'd0, dx:2'd1, dy:2'd3, nbody:0, good:1'b0};
      tbl[5] = '{sx:2'd3, sy:2'd3, dx:2'd1, dy:2'd2, nbody:5, good:1'b1};
      tbl[6] = '{sx:2'd1, sy:2'd2, dx:2'd0, dy:2'd2, nbody:1, good:1'b0};

      repeat (3) @(negedge noc_clk);
      noc_rst = 1'b0;
      @(negedge noc_clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_flags", {out_valid, out_last, out_err, pkt_done, err_pulse}, 5'b0);
      chk("rst_counters", {pkt_cnt, drop_cnt}, 32'h0);

      for (int k = 0; k < 7; k++) begin
         send(1'b1, 1'b0, hdr_pl(tbl[k].sx, tbl[k].sy, tbl[k].dx, tbl[k].dy));
         for (int i = 0; i < tbl[k].nbody; i++) begin
            d = {$urandom, $urandom};
            if (tbl[k].good) exp_q.push_back({d, i == tbl[k].nbody - 1, 1'b0, tbl[k].sx, tbl[k].sy});
            send(1'b0, 1'b0, d);
         end
         send(1'b0, 1'b1, {$urandom, $urandom});
         if (tbl[k].good) begin exp_pkt++; exp_done++; end
         else begin exp_drop++; exp_err++; end
         drain();
         chk_cnt($sformatf("tbl%0d", k));
      end

      // Backpressure: 8-body packet with the consumer stalled.
      out_ready = 1'b0;
      snd_done  = 1'b0;
      acc_cnt   = 0;
      fork
         begin
            send(1'b1, 1'b0, hdr_pl(2'd2, 2'd0, 2'd1, 2'd2));
            for (int i = 0; i < 8; i++) begin
               d = {$urandom, $urandom};
               if (i == 0) bp_first = d;
               exp_q.push_back({d, i == 7, 1'b0, 2'd2, 2'd0});
               send(1'b0, 1'b0, d);
            end
            send(1'b0, 1'b1, 64'h0);
            snd_done = 1'b1;
         end
      join_none
      repeat (30) @(negedge noc_clk);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_flits_accepted", acc_cnt, 6);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_head_held", out_data, bp_first);
      out_ready = 1'b1;
      for (int w = 0; w < 400 && !snd_done; w++) @(negedge noc_clk);
      chk("bp_sender_done", snd_done, 1'b1);
      exp_pkt++; exp_done++;
      drain();
      chk_cnt("bp");

      // Truncated packet followed by a fresh good header.
      send(1'b1, 1'b0, hdr_pl(2'd2, 2'd1, 2'd1, 2'd2));
      d = 64'hD0D0_1111_2222_3333;
      exp_q.push_back({d, 1'b1, 1'b1, 2'd2, 2'd1});
      send(1'b0, 1'b0, d);
      send(1'b1, 1'b0, hdr_pl(2'd0, 2'd3, 2'd1, 2'd2));
      d = 64'hE0E0_4444_5555_6666;
      exp_q.push_back({d, 1'b1, 1'b0, 2'd0, 2'd3});
      send(1'b0, 1'b0, d);
      send(1'b0, 1'b1, 64'h0);
      exp_pkt++; exp_done++; exp_err++;
      drain();
      chk_cnt("trunc");

      // Stray body in IDLE, then single-flit packets good and misrouted.
      send(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
      exp_drop++; exp_err++;
      drain();
      chk_cnt("stray");
      send(1'b1, 1'b1, hdr_pl(2'd3, 2'd1, 2'd1, 2'd2));
      exp_pkt++; exp_done++;
      drain();
      chk_cnt("single_good");
      send(1'b1, 1'b1, hdr_pl(2'd3, 2'd1, 2'd3, 2'd2));
      exp_drop++; exp_err++;
      drain();
      chk_cnt("single_bad");

      // Reset in the middle of a packet.
      out_ready = 1'b0;
      send(1'b1, 1'b0, hdr_pl(2'd1, 2'd0, 2'd1, 2'd2));
      send(1'b0, 1'b0, 64'hAAAA_0000_0000_0001);
      send(1'b0, 1'b0, 64'hAAAA_0000_0000_0002);
      chk("pre_rst_out_valid", out_valid, 1'b1);
      noc_rst = 1'b1;
      @(negedge noc_clk);
      chk("mid_rst_outputs", {out_valid, out_last, out_err, pkt_done, err_pulse, pkt_cnt, drop_cnt}, '0);
      noc_rst = 1'b0;
      @(negedge noc_clk);
      chk("post_rst_in_ready", in_ready, 1'b1);
      exp_pkt = 0; exp_drop = 0;
      out_ready = 1'b1;
      send(1'b1, 1'b0, hdr_pl(2'd0, 2'd2, 2'd1, 2'd2));
      for (int i = 0; i < 2; i++) begin
         d = {$urandom, $urandom};
         exp_q.push_back({d, i == 1, 1'b0, 2'd0, 2'd2});
         send(1'b0, 1'b0, d);
      end
      send(1'b0, 1'b1, 64'h0);
      exp_pkt++; exp_done++;
      drain();
      chk_cnt("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
